// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame check, E0/F0 prefix decode, event FIFO, digit map.
// Latency: event valid one cycle after the filtered stop-bit edge; backpressure via key_valid_o/key_ready_i, drop + overflow_o when full.
module ps2_keypad_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic                          key_valid_o,
    input  logic                          key_ready_i,
    output logic [7:0]                    key_code_o,
    output logic                          key_break_o,
    output logic                          key_ext_o,
    output logic                          key_is_digit_o,
    output logic [3:0]                    key_digit_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_filt;
    logic [FW-1:0] r_flt_cnt;
    logic          r_fall;
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_bit;
    logic [TW-1:0] r_to_cnt;
    logic          r_ext, r_brk;
    logic          r_parity_err, r_frame_err, r_overflow;
    logic          w_timeout, w_byte_ok, w_par_err, w_frm_err;
    logic          w_push, w_pop, w_full, w_push_ok;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_fill;
    logic [9:0]    w_head;

    // Input synchronisers and level filter; idle bus is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_i;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_MAX) begin
                r_flt_cnt  <= '0;
                r_clk_filt <= r_clk_s2;
                r_fall     <= r_clk_filt & ~r_clk_s2;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_timeout = (r_state != IDLE) && !r_fall && (r_to_cnt == TO_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_par_err   = 1'b0;
        w_frm_err   = 1'b0;
        if (w_timeout) begin
            w_frm_err   = 1'b1;
            w_state_nxt = IDLE;
        end else if (r_fall) begin
            case (r_state)
                IDLE:   if (!r_dat_s2) w_state_nxt = DATA;
                DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (!r_dat_s2)                    w_frm_err = 1'b1;
                    else if (!(^{r_shift, r_par_bit})) w_par_err = 1'b1;
                    else                              w_byte_ok = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (r_fall || r_state == IDLE) r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX)   r_to_cnt <= r_to_cnt + 1'b1;
            if (r_fall) begin
                case (r_state)
                    IDLE: r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY: r_par_bit <= r_dat_s2;
                    default: ;
                endcase
            end
        end
    end

    assign w_push    = w_byte_ok && (r_shift != 8'hE0) && (r_shift != 8'hF0);
    assign w_pop     = key_valid_o && key_ready_i;
    assign w_full    = (r_fill == FILL_MAX);
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_fill       <= '0;
        end else begin
            r_parity_err <= w_par_err;
            r_frame_err  <= w_frm_err;
            r_overflow   <= w_push && !w_push_ok;
            if (w_par_err || w_frm_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shift == 8'hE0)      r_ext <= 1'b1;
                else if (r_shift == 8'hF0) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr] <= {r_ext, r_brk, r_shift};
    end

    assign key_valid_o = (r_fill != '0);
    assign w_head      = key_valid_o ? r_mem[r_rptr] : 10'd0;
    assign key_code_o  = w_head[7:0];
    assign key_break_o = w_head[8];
    assign key_ext_o   = w_head[9];
    assign fill_o      = r_fill;
    assign parity_err_o = r_parity_err;
    assign frame_err_o  = r_frame_err;
    assign overflow_o   = r_overflow;

    // Main-row and keypad digits; extended codes never map.
    always_comb begin
        key_is_digit_o = 1'b0;
        key_digit_o    = 4'd0;
        if (key_valid_o && !w_head[9]) begin
            key_is_digit_o = 1'b1;
            case (w_head[7:0])
                8'h45, 8'h70: key_digit_o = 4'd0;
                8'h16, 8'h69: key_digit_o = 4'd1;
                8'h1E, 8'h72: key_digit_o = 4'd2;
                8'h26, 8'h7A: key_digit_o = 4'd3;
                8'h25, 8'h6B: key_digit_o = 4'd4;
                8'h2E, 8'h73: key_digit_o = 4'd5;
                8'h36, 8'h74: key_digit_o = 4'd6;
                8'h3D, 8'h6C: key_digit_o = 4'd7;
                8'h3E, 8'h75: key_digit_o = 4'd8;
                8'h46, 8'h7D: key_digit_o = 4'd9;
                default:      key_is_digit_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Directed bench for ps2_keypad_rx: frames, prefixes, errors, timeout, overflow, glitches, mid-frame reset.
module tb_ps2_keypad_rx;

    localparam int FLT = 4;
    localparam int TO  = 200;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rdy = 1'b0;
    logic       vld, brk, ext, isdig, perr, ferr, ovf;
    logic [7:0] code;
    logic [3:0] dig;
    logic [$clog2(DEP):0] fill;

    int n_vec = 0;
    int n_bad = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;

    ps2_keypad_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEP)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_dat),
        .key_valid_o(vld), .key_ready_i(rdy), .key_code_o(code),
        .key_break_o(brk), .key_ext_o(ext), .key_is_digit_o(isdig),
        .key_digit_o(dig), .fill_o(fill), .parity_err_o(perr),
        .frame_err_o(ferr), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (perr) n_par <= n_par + 1;
        if (ferr) n_frm <= n_frm + 1;
        if (ovf)  n_ovf <= n_ovf + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            repeat (10) @(negedge clk);
            if (glitch) begin ps2_clk = 1'b0; @(negedge clk); ps2_clk = 1'b1; end
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (glitch) begin ps2_clk = 1'b1; @(negedge clk); ps2_clk = 1'b0; end
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit stop, input bit glitch);
        logic [10:0] bits;
        bits = {stop, (~^c) ^ bad_par, c, 1'b0};
        send_bits(bits, 11, glitch);
        repeat (30) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] c, input bit b, input bit e,
                           input bit d, input logic [3:0] dv);
        chk({tag, "_vld"}, vld, 1'b1);
        chk({tag, "_code"}, code, c);
        chk({tag, "_brk"}, brk, b);
        chk({tag, "_ext"}, ext, e);
        chk({tag, "_isdig"}, isdig, d);
        chk({tag, "_dig"}, dig, dv);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    logic [7:0] ovf_codes [DEP+1];
    logic [3:0] ovf_digs  [DEP+1];
    int p0, f0, o0;

    initial begin
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        ovf_digs  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        repeat (4) @(negedge clk);
        chk("rst_vld", vld, 1'b0);
        chk("rst_fill", fill, 0);
        chk("rst_perr", perr, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_vld", vld, 1'b0);
        chk("idle_code", code, 8'h00);

        send_frame(8'h16, 0, 1, 0);
        chk("f16_fill", fill, 1);
        pop_chk("f16", 8'h16, 0, 0, 1, 4'd1);
        chk("f16_pop_vld", vld, 1'b0);
        chk("f16_pop_fill", fill, 0);

        send_frame(8'hF0, 0, 1, 0);
        chk("f0_nopush", fill, 0);
        send_frame(8'h70, 0, 1, 0);
        chk("brk70_fill", fill, 1);
        pop_chk("brk70", 8'h70, 1, 0, 1, 4'd0);

        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'h70, 0, 1, 0);
        chk("ext70_fill", fill, 1);
        pop_chk("ext70", 8'h70, 0, 1, 0, 4'd0);

        p0 = n_par; f0 = n_frm;
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h1E, 1, 1, 0);
        chk("par_pulse", n_par - p0, 1);
        chk("par_nofrm", n_frm - f0, 0);
        chk("par_noevt", fill, 0);
        send_frame(8'h26, 0, 1, 0);
        pop_chk("after_par", 8'h26, 0, 0, 1, 4'd3);

        p0 = n_par; f0 = n_frm;
        send_frame(8'h2E, 1, 0, 0);
        chk("stop0_frm", n_frm - f0, 1);
        chk("stop0_nopar", n_par - p0, 0);
        chk("stop0_noevt", fill, 0);
        f0 = n_frm;
        send_bits(11'b00000000110, 4, 0);
        repeat (TO + 50) @(negedge clk);
        chk("tmo_frm", n_frm - f0, 1);
        send_frame(8'h25, 0, 1, 0);
        pop_chk("after_tmo", 8'h25, 0, 0, 1, 4'd4);

        o0 = n_ovf;
        for (int i = 0; i <= DEP; i++) send_frame(ovf_codes[i], 0, 1, 0);
        chk("ovf_fill", fill, DEP);
        chk("ovf_pulse", n_ovf - o0, 1);
        for (int i = 0; i < DEP; i++) pop_chk($sformatf("ovf%0d", i), ovf_codes[i], 0, 0, 1, ovf_digs[i]);
        chk("ovf_empty", vld, 1'b0);

        send_frame(8'h7D, 0, 1, 1);
        chk("glitch_fill", fill, 1);
        pop_chk("glitch", 8'h7D, 0, 0, 1, 4'd9);

        p0 = n_par; f0 = n_frm;
        send_bits(11'b11111111110, 6, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (TO + 50) @(negedge clk);
        chk("mrst_noevt", vld, 1'b0);
        chk("mrst_nofrm", n_frm - f0, 0);
        chk("mrst_nopar", n_par - p0, 0);
        send_frame(8'h45, 0, 1, 0);
        pop_chk("after_mrst", 8'h45, 0, 0, 1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
